// File: rtl/re_mapper_ctrl.sv
// RE-mapper ping-pong buffer sequencer: turns a valid/ready sample stream
// into buffer writes, then paces Sym_Done/RE_Done around the buffer readout.
//
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   cfg_start        one-cycle pulse, latches cfg_num_sc/cfg_num_sym in IDLE
//   cfg_num_sc       REs per symbol (1..MEM_DEPTH-WRITE_ADDR_SHIFT)
//   cfg_num_sym      symbols per slot (1..14)
//   in_valid/in_data sample stream, in_ready = state is FILL
//   write_enable     registered buffer write strobe
//   write_addr       registered write address, 0..num_sc-1
//   data_in          registered copy of the accepted sample
//   Sym_Done/RE_Done one-cycle symbol / slot completion pulses
//   busy             slot in progress (through the RE_Done cycle)
//   sym_idx          symbol being filled
//   cfg_err          one-cycle pulse on a rejected configuration
module re_mapper_ctrl #(
    parameter int MEM_DEPTH        = 2048,
    parameter int FFT_Len          = 18,
    parameter int WRITE_ADDR_SHIFT = 423,
    parameter int DRAIN_CYCLES     = 2050
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      cfg_start,
    input  logic [10:0]               cfg_num_sc,
    input  logic [3:0]                cfg_num_sym,
    input  logic                      in_valid,
    input  logic signed [FFT_Len-1:0] in_data,
    output logic                      in_ready,
    output logic                      write_enable,
    output logic [10:0]               write_addr,
    output logic signed [FFT_Len-1:0] data_in,
    output logic                      Sym_Done,
    output logic                      RE_Done,
    output logic                      busy,
    output logic [3:0]                sym_idx,
    output logic                      cfg_err
);

    localparam int MAX_SC = MEM_DEPTH - WRITE_ADDR_SHIFT;
    localparam int DW     = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        FLUSH,
        WAIT_SWAP,
        WAIT_END
    } state_t;

    state_t         state;
    logic [10:0]    num_sc;
    logic [3:0]     num_sym;
    logic [10:0]    addr_cnt;
    logic [DW-1:0]  drain_cnt;
    logic [DW-1:0]  drain_nxt;
    logic           cfg_ok;
    logic           last_re;
    logic           more_sym;

    assign in_ready  = (state == FILL);
    assign drain_nxt = (drain_cnt != '0) ? drain_cnt - 1'b1 : '0;
    assign cfg_ok    = (cfg_num_sc != 11'd0)
                    && (int'(cfg_num_sc) <= MAX_SC)
                    && (cfg_num_sym != 4'd0)
                    && (cfg_num_sym <= 4'd14);
    assign last_re   = (addr_cnt == num_sc - 11'd1);
    assign more_sym  = (sym_idx < num_sym - 4'd1);

    // Sym_Done/RE_Done are registered one cycle ahead: the pulse is raised on
    // the edge where the drain counter reaches zero, and the drain reload
    // happens on that same edge, so the counter reads DRAIN_CYCLES in the
    // pulse cycle and zero exactly DRAIN_CYCLES cycles later.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            num_sc       <= '0;
            num_sym      <= '0;
            addr_cnt     <= '0;
            drain_cnt    <= '0;
            write_enable <= 1'b0;
            write_addr   <= '0;
            data_in      <= '0;
            Sym_Done     <= 1'b0;
            RE_Done      <= 1'b0;
            busy         <= 1'b0;
            sym_idx      <= '0;
            cfg_err      <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            Sym_Done     <= 1'b0;
            RE_Done      <= 1'b0;
            cfg_err      <= 1'b0;
            drain_cnt    <= drain_nxt;
            unique case (state)
                IDLE: begin
                    if (cfg_start) begin
                        if (cfg_ok) begin
                            num_sc   <= cfg_num_sc;
                            num_sym  <= cfg_num_sym;
                            busy     <= 1'b1;
                            sym_idx  <= '0;
                            addr_cnt <= '0;
                            state    <= FILL;
                        end else begin
                            cfg_err  <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        write_enable <= 1'b1;
                        write_addr   <= addr_cnt;
                        data_in      <= in_data;
                        if (last_re) begin
                            state <= FLUSH;
                        end else begin
                            addr_cnt <= addr_cnt + 11'd1;
                        end
                    end
                end
                FLUSH: begin
                    state <= WAIT_SWAP;
                    if (drain_nxt == '0) begin
                        Sym_Done  <= 1'b1;
                        drain_cnt <= DW'(DRAIN_CYCLES);
                    end
                end
                WAIT_SWAP: begin
                    if (Sym_Done) begin
                        if (more_sym) begin
                            sym_idx  <= sym_idx + 4'd1;
                            addr_cnt <= '0;
                            state    <= FILL;
                        end else begin
                            state    <= WAIT_END;
                        end
                    end else if (drain_nxt == '0) begin
                        Sym_Done  <= 1'b1;
                        drain_cnt <= DW'(DRAIN_CYCLES);
                    end
                end
                WAIT_END: begin
                    if (RE_Done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (drain_nxt == '0) begin
                        RE_Done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_re_mapper_ctrl.sv
// Self-checking bench for re_mapper_ctrl: scoreboard of expected buffer
// writes plus a timing model of Sym_Done/RE_Done pacing.
module tb_re_mapper_ctrl;

    localparam int DRAIN = 2050;

    logic               CLK = 1'b0;
    logic               RST;
    logic               cfg_start;
    logic [10:0]        cfg_num_sc;
    logic [3:0]         cfg_num_sym;
    logic               in_valid;
    logic signed [17:0] in_data;
    logic               in_ready;
    logic               write_enable;
    logic [10:0]        write_addr;
    logic signed [17:0] data_in;
    logic               Sym_Done;
    logic               RE_Done;
    logic               busy;
    logic [3:0]         sym_idx;
    logic               cfg_err;

    int checks = 0;
    int errors = 0;

    // bench model state
    logic [28:0] q[$];
    int  cyc = 0;
    int  cur_sc = 1;
    int  cur_sym = 1;
    int  hs_cnt = 0;
    logic [3:0] exp_sym = '0;
    bit  pend = 0;
    bit  first_sd = 1;
    int  last_hs = 0;
    int  prev_sd = 0;
    int  sd_cnt = 0;
    int  re_cnt = 0;
    int  wr_total = 0;
    int  err_cnt = 0;

    re_mapper_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .cfg_start    (cfg_start),
        .cfg_num_sc   (cfg_num_sc),
        .cfg_num_sym  (cfg_num_sym),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .data_in      (data_in),
        .Sym_Done     (Sym_Done),
        .RE_Done      (RE_Done),
        .busy         (busy),
        .sym_idx      (sym_idx),
        .cfg_err      (cfg_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Monitor: samples on the falling edge, inputs change just after rising.
    always @(negedge CLK) begin
        logic [28:0] e;
        int ec;
        cyc++;
        if (write_enable) begin
            wr_total++;
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow observed=write addr %0d expected=no write",
                       write_addr);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                assert ({write_addr, data_in} === e) else begin
                    errors++;
                    $error("FAIL write observed=%0d/%0d expected=%0d/%0d",
                           write_addr, data_in, e[28:18], $signed(e[17:0]));
                end
            end
        end
        checks++;
        assert (!(write_enable && Sym_Done)) else begin
            errors++;
            $error("FAIL we_vs_sym observed=1 expected=0 at cycle %0d", cyc);
        end
        checks++;
        assert (!(Sym_Done && RE_Done)) else begin
            errors++;
            $error("FAIL sym_vs_re observed=1 expected=0 at cycle %0d", cyc);
        end
        if (cfg_err) err_cnt++;
        if (RST) begin
            q.delete();
            hs_cnt = 0;
            pend = 0;
            exp_sym = '0;
            first_sd = 1;
        end else begin
            if (pend) begin
                checks++;
                assert (in_ready === 1'b0) else begin
                    errors++;
                    $error("FAIL ready_stall observed=%0b expected=0 at cycle %0d",
                           in_ready, cyc);
                end
            end
            if (Sym_Done) begin
                ec = last_hs + 2;
                if (!first_sd && prev_sd + DRAIN > ec) ec = prev_sd + DRAIN;
                checks++;
                assert (cyc === ec) else begin
                    errors++;
                    $error("FAIL sym_time observed=%0d expected=%0d", cyc, ec);
                end
                prev_sd = cyc;
                first_sd = 0;
                pend = 0;
                sd_cnt++;
            end
            if (RE_Done) begin
                checks++;
                assert (cyc === prev_sd + DRAIN) else begin
                    errors++;
                    $error("FAIL re_time observed=%0d expected=%0d",
                           cyc, prev_sd + DRAIN);
                end
                re_cnt++;
                first_sd = 1;
            end
            if (in_valid && in_ready) begin
                checks++;
                assert (sym_idx === exp_sym) else begin
                    errors++;
                    $error("FAIL sym_idx observed=%0d expected=%0d", sym_idx, exp_sym);
                end
                q.push_back({11'(hs_cnt), in_data});
                last_hs = cyc;
                hs_cnt++;
                if (hs_cnt == cur_sc) begin
                    hs_cnt = 0;
                    pend = 1;
                    if (int'(exp_sym) < cur_sym - 1) exp_sym++;
                end
            end
        end
    end

    task automatic start(int sc, int sym);
        @(posedge CLK); #1;
        cfg_num_sc  = 11'(sc);
        cfg_num_sym = 4'(sym);
        cfg_start   = 1'b1;
        @(posedge CLK); #1;
        cfg_start   = 1'b0;
    endtask

    task automatic arm(int sc, int sym);
        cur_sc  = sc;
        cur_sym = sym;
        hs_cnt  = 0;
        exp_sym = '0;
    endtask

    task automatic run_slot(int sc, int sym, bit tog, bit poke);
        int base_re = re_cnt;
        int base_wr = wr_total;
        int base_sd = sd_cnt;
        int base_er = err_cnt;
        int budget  = sym * (2 * sc + DRAIN + 50) + 200;
        arm(sc, sym);
        in_valid = 1'b1;
        start(sc, sym);
        for (int i = 0; i < budget && re_cnt == base_re; i++) begin
            @(posedge CLK); #1;
            in_data   = 18'($urandom);
            if (tog) in_valid = !in_valid;
            cfg_start = poke && (i == 3);
            if (poke && i == 3) begin
                cfg_num_sc  = 11'd5;
                cfg_num_sym = 4'd3;
            end
        end
        in_valid = 1'b0;
        chk("re_done_count", re_cnt - base_re, 1);
        chk("write_count", wr_total - base_wr, sc * sym);
        chk("sym_done_count", sd_cnt - base_sd, sym);
        chk("sb_empty", q.size(), 0);
        chk("no_cfg_err", err_cnt - base_er, 0);
        @(negedge CLK);
        chk("busy_after_re", busy, 0);
        chk("sym_idx_end", sym_idx, sym - 1);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_we"}, write_enable, 0);
        chk({tag, "_addr"}, write_addr, 0);
        chk({tag, "_data"}, data_in, 0);
        chk({tag, "_sym"}, Sym_Done, 0);
        chk({tag, "_re"}, RE_Done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_idx"}, sym_idx, 0);
        chk({tag, "_err"}, cfg_err, 0);
        chk({tag, "_rdy"}, in_ready, 0);
    endtask

    initial begin
        int base_er;
        int base_wr;
        int base_sd;
        int n;
        RST         = 1'b1;
        cfg_start   = 1'b0;
        cfg_num_sc  = '0;
        cfg_num_sym = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_zero("reset");
        @(posedge CLK); #1;
        RST = 1'b0;

        // 1: single symbol, 12 REs
        run_slot(12, 1, 0, 0);

        // 2: three symbols back to back, drain-limited swaps
        run_slot(24, 3, 0, 0);

        // 3: maximum symbol length with bursty input
        run_slot(1625, 1, 1, 0);

        // 4: illegal configurations
        base_er = err_cnt;
        base_wr = wr_total;
        in_valid = 1'b1;
        start(0, 1);
        @(negedge CLK);
        chk("err_sc0", cfg_err, 1);
        chk("err_sc0_busy", busy, 0);
        start(1626, 1);
        @(negedge CLK);
        chk("err_sc1626", cfg_err, 1);
        chk("err_sc1626_busy", busy, 0);
        start(12, 15);
        @(negedge CLK);
        chk("err_sym15", cfg_err, 1);
        @(negedge CLK);
        chk("err_pulse_len", cfg_err, 0);
        chk("err_busy", busy, 0);
        chk("err_count", err_cnt - base_er, 3);
        chk("err_no_writes", wr_total - base_wr, 0);
        in_valid = 1'b0;

        // 5: reset in the middle of filling symbol 1 of 2
        arm(20, 2);
        base_sd = sd_cnt;
        in_valid = 1'b1;
        start(20, 2);
        n = 0;
        while (sd_cnt == base_sd && n < 200) begin
            @(posedge CLK); #1;
            in_data = 18'($urandom);
            n++;
        end
        chk("pre_reset_sym", sd_cnt - base_sd, 1);
        repeat (5) begin
            @(posedge CLK); #1;
            in_data = 18'($urandom);
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        in_valid = 1'b0;
        @(negedge CLK);
        chk_zero("midreset");
        base_sd = sd_cnt;
        repeat (10) @(negedge CLK);
        chk("no_sym_after_reset", sd_cnt - base_sd, 0);
        run_slot(16, 2, 0, 0);

        // 6: cfg_start pulsed mid-slot is ignored
        run_slot(10, 1, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
